// File: rtl/ksa_pkg.sv
// Shared types and elaboration helpers for the Kogge-Stone adder.
package ksa_pkg;

    // Group generate/propagate pair carried through the prefix tree.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of prefix levels: ceil(log2(n)), 0 when n == 1.
    function automatic int unsigned prefix_depth(input int unsigned n);
        int unsigned d;
        d = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((64'd1 << k) < 64'(n)) begin
                d = k + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/ksa_pg_cell.sv
// Black prefix cell: merges a higher group (hi) with the adjacent lower group (lo).
module ksa_pg_cell (
    input  logic i_g_hi,
    input  logic i_p_hi,
    input  logic i_g_lo,
    input  logic i_p_lo,
    output logic o_g,
    output logic o_p
);

    assign o_g = i_g_hi | (i_p_hi & i_g_lo);
    assign o_p = i_p_hi & i_p_lo;

endmodule

// File: rtl/ksa_adder.sv
// N-bit Kogge-Stone adder: {cout, s} = a + b + cin.
// Define KSA_OUT_REG_EN to register s/cout (1-cycle latency, sync active-low reset).
module ksa_adder
    import ksa_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    localparam int unsigned LVL = prefix_depth(N);

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N-1:0] w_c;
    logic [N-1:0] w_s;
    logic         w_cout;
    logic [N-1:0] w_p_final;
    gp_t          w_gp [0:LVL][0:N-1];

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Level 0: cin enters as the bit -1 generate, so bit 0's group propagate is 0.
    for (genvar i = 0; i < N; i++) begin : g_pre
        if (i == 0) begin : g_bit0
            assign w_gp[0][i] = gp_t'{g: w_g[0] | (w_p[0] & cin), p: 1'b0};
        end else begin : g_bitn
            assign w_gp[0][i] = gp_t'{g: w_g[i], p: w_p[i]};
        end
    end

    // Full-width prefix levels; bits below the span pass through.
    for (genvar k = 0; k < LVL; k++) begin : g_lvl
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_cell
                logic w_cg;
                logic w_cp;
                ksa_pg_cell u_cell (
                    .i_g_hi (w_gp[k][i].g),
                    .i_p_hi (w_gp[k][i].p),
                    .i_g_lo (w_gp[k][i - (1 << k)].g),
                    .i_p_lo (w_gp[k][i - (1 << k)].p),
                    .o_g    (w_cg),
                    .o_p    (w_cp)
                );
                assign w_gp[k+1][i] = gp_t'{g: w_cg, p: w_cp};
            end else begin : g_pass
                assign w_gp[k+1][i] = w_gp[k][i];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_post
        if (i == 0) begin : g_c0
            assign w_c[i] = cin;
        end else begin : g_cn
            assign w_c[i] = w_gp[LVL][i-1].g;
        end
        assign w_p_final[i] = w_gp[LVL][i].p;
    end

    assign w_s    = w_p ^ w_c;
    assign w_cout = w_gp[LVL][N-1].g;

`ifdef KSA_OUT_REG_EN
    logic [N-1:0] r_s;
    logic         r_cout;
    logic         w_unused;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_s;
            r_cout <= w_cout;
        end
    end

    assign s        = r_s;
    assign cout     = r_cout;
    assign w_unused = ^w_p_final;
`else
    logic w_unused;

    assign s        = w_s;
    assign cout     = w_cout;
    assign w_unused = ^{clk, reset, w_p_final};
`endif

endmodule

// File: tb/tb_ksa_adder.sv
// Self-checking bench for ksa_adder at N = 16, 13, 4 and 1 against plain-arithmetic sums.
module tb_ksa_adder;

    logic clk;
    logic reset;

    logic [15:0] a16, b16, s16;
    logic        cin16, cout16;
    logic [12:0] a13, b13, s13;
    logic        cin13, cout13;
    logic [3:0]  a4, b4, s4;
    logic        cin4, cout4;
    logic [0:0]  a1, b1, s1;
    logic        cin1, cout1;

    int n_chk  = 0;
    int n_pass = 0;

    ksa_adder #(.N(16)) dut16 (.clk(clk), .reset(reset), .a(a16), .b(b16), .cin(cin16), .s(s16), .cout(cout16));
    ksa_adder #(.N(13)) dut13 (.clk(clk), .reset(reset), .a(a13), .b(b13), .cin(cin13), .s(s13), .cout(cout13));
    ksa_adder #(.N(4))  dut4  (.clk(clk), .reset(reset), .a(a4),  .b(b4),  .cin(cin4),  .s(s4),  .cout(cout4));
    ksa_adder #(.N(1))  dut1  (.clk(clk), .reset(reset), .a(a1),  .b(b1),  .cin(cin1),  .s(s1),  .cout(cout1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled once settled.
    task automatic settle();
`ifdef KSA_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic drive_all(input logic [15:0] x16, input logic [15:0] y16, input logic c16,
                             input logic [12:0] x13, input logic [12:0] y13, input logic c13,
                             input logic [3:0] x4, input logic [3:0] y4, input logic c4,
                             input logic x1, input logic y1, input logic c1);
        @(negedge clk);
        a16 = x16; b16 = y16; cin16 = c16;
        a13 = x13; b13 = y13; cin13 = c13;
        a4  = x4;  b4  = y4;  cin4  = c4;
        a1  = x1;  b1  = y1;  cin1  = c1;
        settle();
    endtask

    function automatic logic [16:0] ref16();
        return 17'(a16) + 17'(b16) + 17'(cin16);
    endfunction
    function automatic logic [13:0] ref13();
        return 14'(a13) + 14'(b13) + 14'(cin13);
    endfunction
    function automatic logic [4:0] ref4();
        return 5'(a4) + 5'(b4) + 5'(cin4);
    endfunction
    function automatic logic [1:0] ref1();
        return 2'(a1) + 2'(b1) + 2'(cin1);
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
    } vec_t;

    vec_t dir [8];
    int   n_bad;

    initial begin
        dir[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        dir[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        dir[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        dir[3] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
        dir[4] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0};
        dir[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        dir[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        dir[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        reset = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0;
        a13 = '0; b13 = '0; cin13 = 1'b0;
        a4  = '0; b4  = '0; cin4  = 1'b0;
        a1  = '0; b1  = '0; cin1  = 1'b0;

`ifdef KSA_OUT_REG_EN
        // Reset held for two edges with non-zero inputs must still clear the outputs.
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_s", 64'(s16), 64'h0);
        chk("reset_cout", 64'(cout16), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b1;
        #1;
        chk("pre_edge_s", 64'(s16), 64'h0);
        @(posedge clk);
        #1;
        chk("lat1_s", 64'(s16), 64'h0003);
        chk("lat1_cout", 64'(cout16), 64'h0);
`else
        repeat (2) @(posedge clk);
        reset = 1'b1;
`endif

        for (int i = 0; i < 8; i++) begin
            drive_all(dir[i].a, dir[i].b, dir[i].cin,
                      13'h0, 13'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("dir%0d_s", i), 64'(s16), 64'(dir[i].s));
            chk($sformatf("dir%0d_cout", i), 64'(cout16), 64'(dir[i].cout));
        end

        // N=13 boundaries: full propagate with cin, and all ones plus cin.
        drive_all(16'h0, 16'h0, 1'b0, 13'h1FFF, 13'h0000, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("n13_prop", 64'({cout13, s13}), 64'h2000);
        drive_all(16'h0, 16'h0, 1'b0, 13'h1FFF, 13'h1FFF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("n13_ones", 64'({cout13, s13}), 64'h3FFF);

        // Random sweep across widths 16 and 13 (and incidental 4/1 coverage).
        n_bad = 0;
        for (int i = 0; i < 1200; i++) begin
            drive_all(16'($urandom), 16'($urandom), 1'($urandom),
                      13'($urandom), 13'($urandom), 1'($urandom),
                      4'($urandom), 4'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom));
            if ({cout16, s16} !== ref16() && n_bad < 5) begin
                n_bad++;
                chk($sformatf("rnd16 a=%h b=%h c=%b", a16, b16, cin16), 64'({cout16, s16}), 64'(ref16()));
            end
            if ({cout13, s13} !== ref13() && n_bad < 5) begin
                n_bad++;
                chk($sformatf("rnd13 a=%h b=%h c=%b", a13, b13, cin13), 64'({cout13, s13}), 64'(ref13()));
            end
        end
        chk("rnd_bad_count", 64'(n_bad), 64'h0);

        // Exhaustive N=4 and N=1.
        n_bad = 0;
        for (int i = 0; i < 512; i++) begin
            drive_all(16'h0, 16'h0, 1'b0, 13'h0, 13'h0, 1'b0,
                      4'(i >> 5), 4'(i >> 1), 1'(i),
                      1'(i >> 2), 1'(i >> 1), 1'(i));
            if ({cout4, s4} !== ref4() && n_bad < 5) begin
                n_bad++;
                chk($sformatf("exh4 a=%h b=%h c=%b", a4, b4, cin4), 64'({cout4, s4}), 64'(ref4()));
            end
            if (i < 8 && {cout1, s1} !== ref1() && n_bad < 5) begin
                n_bad++;
                chk($sformatf("exh1 a=%b b=%b c=%b", a1, b1, cin1), 64'({cout1, s1}), 64'(ref1()));
            end
        end
        chk("exh_bad_count", 64'(n_bad), 64'h0);

        // Explicit full-adder corner for N=1.
        drive_all(16'h0, 16'h0, 1'b0, 13'h0, 13'h0, 1'b0, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("n1_111", 64'({cout1, s1}), 64'h3);
        chk("n4_prop", 64'({cout4, s4}), 64'h10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
